// File: rtl/insn_encoder_if.sv
// ---------------------------------------------------------------------------
// insn_encoder_if
// Bundles the producer-side and consumer-side handshakes of the instruction
// encoder together with the decoded instruction fields, the address-load
// controls and the status outputs.
//
//   in_valid/in_ready     : decoded-instruction handshake (producer -> encoder)
//   in_op/in_rd/in_rs/in_rt/in_shamt/in_imm/in_target : decoded fields
//   addr_load/addr_value  : overwrite the instruction-memory address counter
//   out_valid/out_ready   : encoded-word handshake (encoder -> consumer)
//   out_insn/out_addr     : encoded 32-bit word and its imem address
//   out_err/err_sticky    : field range error (current word / since reset)
//   insn_count            : words accepted by the consumer, wraps at 16 bits
//
// Modports: master = harness / loader side, slave = encoder side.
// ---------------------------------------------------------------------------
interface insn_encoder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [4:0]            in_shamt;
    logic [31:0]           in_imm;
    logic [31:0]           in_target;
    logic                  addr_load;
    logic [ADDR_WIDTH-1:0] addr_value;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_insn;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;
    logic                  err_sticky;
    logic [15:0]           insn_count;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target,
        output addr_load, addr_value, out_ready,
        input  in_ready, out_valid, out_insn, out_addr, out_err, err_sticky, insn_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target,
        input  addr_load, addr_value, out_ready,
        output in_ready, out_valid, out_insn, out_addr, out_err, err_sticky, insn_count
    );
endinterface

// File: rtl/insn_encoder.sv
// ---------------------------------------------------------------------------
// insn_encoder
// Streaming instruction encoder. Takes one decoded instruction per handshake
// and produces the 32-bit machine word plus the instruction-memory address it
// belongs at. Used to build imem images from the harness and boot loader.
//
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; discards any pending output word
//   bus   : insn_encoder_if slave modport (handshakes, fields, status)
//
// Parameters:
//   ADDR_WIDTH : width of the address counter and out_addr
//   BASE_ADDR  : counter value after reset
//
// One-deep registered output stage: a word is loaded one cycle after the
// input transfer and held until the consumer takes it. Accepting a new word
// in the same cycle the old one leaves sustains one word per clock.
// ---------------------------------------------------------------------------
module insn_encoder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic          clock,
    input  logic          reset,
    insn_encoder_if.slave bus
);

    // Mnemonic select values on in_op.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_JAL  = 4'd11;
    localparam logic [3:0] OP_JR   = 4'd12;
    localparam logic [3:0] OP_BLT  = 4'd13;
    localparam logic [3:0] OP_BEX  = 4'd14;
    localparam logic [3:0] OP_SETX = 4'd15;

    // Machine opcodes, bits [31:27] of the encoded word.
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_J     = 5'b00001;
    localparam logic [4:0] OPC_BNE   = 5'b00010;
    localparam logic [4:0] OPC_JAL   = 5'b00011;
    localparam logic [4:0] OPC_JR    = 5'b00100;
    localparam logic [4:0] OPC_ADDI  = 5'b00101;
    localparam logic [4:0] OPC_BLT   = 5'b00110;
    localparam logic [4:0] OPC_SW    = 5'b00111;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SETX  = 5'b10101;
    localparam logic [4:0] OPC_BEX   = 5'b10110;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    logic                  out_valid_q;
    logic [31:0]           out_insn_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic                  out_err_q;
    logic                  err_sticky_q;
    logic [15:0]           insn_count_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_d;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic in_xfer;
    logic out_xfer;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = out_valid_q && bus.out_ready;

    // A load in the same cycle as an accepted word places that word at the
    // loaded address, so the counter moves on from there.
    assign word_addr = bus.addr_load ? bus.addr_value : addr_cnt_q;

    always_comb begin
        addr_cnt_d = addr_cnt_q;
        if (bus.addr_load) begin
            addr_cnt_d = bus.addr_value;
        end
        if (in_xfer) begin
            addr_cnt_d = word_addr + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction class decode
    // -----------------------------------------------------------------------
    logic is_rtype;
    logic is_shift;
    logic is_itype;
    logic is_jitype;
    logic is_jr;

    always_comb begin
        is_rtype  = 1'b0;
        is_shift  = 1'b0;
        is_itype  = 1'b0;
        is_jitype = 1'b0;
        is_jr     = 1'b0;
        unique case (bus.in_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype = 1'b1;
            OP_SLL, OP_SRA: begin
                is_rtype = 1'b1;
                is_shift = 1'b1;
            end
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: is_itype  = 1'b1;
            OP_J, OP_JAL, OP_BEX, OP_SETX:         is_jitype = 1'b1;
            OP_JR:                                 is_jr     = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Opcode select
    // -----------------------------------------------------------------------
    logic [4:0] opcode;

    always_comb begin
        opcode = OPC_RTYPE;
        case (bus.in_op)
            OP_ADDI: opcode = OPC_ADDI;
            OP_SW:   opcode = OPC_SW;
            OP_LW:   opcode = OPC_LW;
            OP_BNE:  opcode = OPC_BNE;
            OP_BLT:  opcode = OPC_BLT;
            OP_J:    opcode = OPC_J;
            OP_JAL:  opcode = OPC_JAL;
            OP_BEX:  opcode = OPC_BEX;
            OP_SETX: opcode = OPC_SETX;
            OP_JR:   opcode = OPC_JR;
            default: opcode = OPC_RTYPE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Field packing and range check
    // -----------------------------------------------------------------------
    logic [31:0] insn_enc;
    logic        err_enc;
    logic        imm_fits;
    logic        target_fits;

    // A 17-bit signed field holds [-65536, 65535]: bits [31:16] must all be
    // copies of bit 16.
    assign imm_fits    = (bus.in_imm[31:16] == {16{bus.in_imm[16]}});
    assign target_fits = (bus.in_target[31:27] == 5'd0);

    always_comb begin
        insn_enc        = '0;
        err_enc         = 1'b0;
        insn_enc[31:27] = opcode;
        if (is_rtype) begin
            insn_enc[26:22] = bus.in_rd;
            insn_enc[21:17] = bus.in_rs;
            // Shifts carry shamt in place of rt; other ALU ops never encode shamt.
            if (is_shift) begin
                insn_enc[11:7] = bus.in_shamt;
            end else begin
                insn_enc[16:12] = bus.in_rt;
            end
            // ALU op code equals the mnemonic index for the six R-type ops.
            insn_enc[6:2] = {2'b00, bus.in_op[2:0]};
        end else if (is_itype) begin
            insn_enc[26:22] = bus.in_rd;
            insn_enc[21:17] = bus.in_rs;
            insn_enc[16:0]  = bus.in_imm[16:0];
            err_enc         = !imm_fits;
        end else if (is_jitype) begin
            insn_enc[26:0] = bus.in_target[26:0];
            err_enc        = !target_fits;
        end else if (is_jr) begin
            insn_enc[26:22] = bus.in_rd;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage, address counter and status
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_insn_q   <= '0;
            out_addr_q   <= BASE_ADDR;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            insn_count_q <= '0;
            addr_cnt_q   <= BASE_ADDR;
        end else begin
            if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_insn_q  <= insn_enc;
                out_addr_q  <= word_addr;
                out_err_q   <= err_enc;
                if (err_enc) begin
                    err_sticky_q <= 1'b1;
                end
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
            if (out_xfer) begin
                insn_count_q <= insn_count_q + 16'd1;
            end
            addr_cnt_q <= addr_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_insn   = out_insn_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_err    = out_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.insn_count = insn_count_q;

endmodule

// File: tb/tb_insn_encoder.sv
// ---------------------------------------------------------------------------
// tb_insn_encoder
// Scoreboard bench for insn_encoder. Accepted inputs push the expected word,
// address and error flag; a negedge monitor pops and compares on every output
// transfer. Scenario tasks add direct checks of handshake and status outputs.
// ---------------------------------------------------------------------------
module tb_insn_encoder;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    insn_encoder_if #(.ADDR_WIDTH(12)) bus ();

    insn_encoder #(.ADDR_WIDTH(12), .BASE_ADDR(12'h000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] insn;
        logic [11:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] exp_addr;
    int          exp_count;
    int          last_stalls;
    int          tests = 0;
    int          fails = 0;

    // Reference encoder, written independently from the field tables.
    function automatic logic [32:0] model_enc(input int op, input int rd, input int rs,
                                              input int rt, input int sh,
                                              input logic [31:0] imm, input logic [31:0] tgt);
        logic [31:0] w;
        logic        e;
        int          opc;
        w = 32'd0;
        e = 1'b0;
        opc = 0;
        if (op <= 5) begin
            w = (32'(rd) << 22) | (32'(rs) << 17) | (32'(op) << 2);
            if (op >= 4) w = w | (32'(sh) << 7);
            else         w = w | (32'(rt) << 12);
        end else if (op == 6 || op == 7 || op == 8 || op == 10 || op == 13) begin
            case (op)
                6:       opc = 5;
                7:       opc = 7;
                8:       opc = 8;
                10:      opc = 2;
                default: opc = 6;
            endcase
            w = (32'(opc) << 27) | (32'(rd) << 22) | (32'(rs) << 17) | (imm & 32'h0001_FFFF);
            e = ($signed(imm) < -65536) || ($signed(imm) > 65535);
        end else if (op == 12) begin
            w = (32'd4 << 27) | (32'(rd) << 22);
        end else begin
            case (op)
                9:       opc = 1;
                11:      opc = 3;
                14:      opc = 22;
                default: opc = 21;
            endcase
            w = (32'(opc) << 27) | (tgt & 32'h07FF_FFFF);
            e = (tgt[31:27] != 5'd0);
        end
        return {e, w};
    endfunction

    // Output monitor: every output transfer is compared against the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_word: got insn=%h addr=%h, expected no word", bus.out_insn, bus.out_addr);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_insn !== mon_e.insn || bus.out_addr !== mon_e.addr || bus.out_err !== mon_e.err) begin
                    fails++;
                    $display("FAIL sb_word: got insn=%h addr=%h err=%b, expected insn=%h addr=%h err=%b",
                             bus.out_insn, bus.out_addr, bus.out_err, mon_e.insn, mon_e.addr, mon_e.err);
                end
            end
            exp_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int op, input int rd, input int rs, input int rt, input int sh,
                        input logic [31:0] imm, input logic [31:0] tgt,
                        input bit ld, input logic [11:0] ldv);
        logic [32:0] m;
        logic [11:0] a;
        int          guard;
        bus.in_valid   = 1'b1;
        bus.in_op      = 4'(op);
        bus.in_rd      = 5'(rd);
        bus.in_rs      = 5'(rs);
        bus.in_rt      = 5'(rt);
        bus.in_shamt   = 5'(sh);
        bus.in_imm     = imm;
        bus.in_target  = tgt;
        bus.addr_load  = ld;
        bus.addr_value = ldv;
        last_stalls = 0;
        guard = 0;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            last_stalls++;
            guard++;
            @(posedge clock);
            #1;
            @(negedge clock);
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", bus.in_ready);
        end else begin
            m = model_enc(op, rd, rs, rt, sh, imm, tgt);
            a = ld ? ldv : exp_addr;
            sb.push_back('{insn: m[31:0], addr: a, err: m[32]});
            exp_addr = a + 12'd1;
        end
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_addr  = 12'h000;
        exp_count = 0;
    endtask

    task automatic test_reset();
        bus.in_op = '0; bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.addr_value = '0;
        do_reset();
        @(negedge clock);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_insn !== 32'h0 || bus.out_addr !== 12'h000 ||
            bus.out_err !== 1'b0 || bus.err_sticky !== 1'b0 || bus.insn_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b insn=%h addr=%h err=%b sticky=%b count=%0d, expected all zero",
                     bus.out_valid, bus.out_insn, bus.out_addr, bus.out_err, bus.err_sticky, bus.insn_count);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_add();
        bus.out_ready = 1'b1;
        send(0, 3, 1, 2, 0, 32'd0, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_insn !== 32'h00C2_2000 || bus.out_addr !== 12'h000 || bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL add_word: got valid=%b insn=%h addr=%h err=%b, expected 1 00c22000 000 0",
                     bus.out_valid, bus.out_insn, bus.out_addr, bus.out_err);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus.insn_count !== 16'(exp_count) || bus.insn_count !== 16'd1) begin
            fails++;
            $display("FAIL add_count: got %0d, expected 1", bus.insn_count);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        do_reset();
        bus.out_ready = 1'b1;
        stalls = 0;
        send(1, 1, 2, 3, 0, 32'd0, 32'd0, 1'b0, 12'h0);
        stalls += last_stalls;
        send(4, 4, 4, 9, 5, 32'd0, 32'd0, 1'b0, 12'h0);
        stalls += last_stalls;
        tests++;
        if (bus.out_insn !== 32'h0108_0290 || bus.out_addr !== 12'h001) begin
            fails++;
            $display("FAIL b2b_sll: got insn=%h addr=%h, expected 01080290 001", bus.out_insn, bus.out_addr);
        end
        send(12, 31, 0, 0, 0, 32'd0, 32'd0, 1'b0, 12'h0);
        stalls += last_stalls;
        tests++;
        if (bus.out_insn !== 32'h27C0_0000 || bus.out_addr !== 12'h002 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_jr: got insn=%h addr=%h valid=%b, expected 27c00000 002 1",
                     bus.out_insn, bus.out_addr, bus.out_valid);
        end
        tests++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL b2b_bubbles: got %0d stall cycles, expected 0", stalls);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus.insn_count !== 16'd3 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_count: got count=%0d valid=%b, expected 3 0", bus.insn_count, bus.out_valid);
        end
    endtask

    task automatic test_imm_range();
        do_reset();
        bus.out_ready = 1'b1;
        send(6, 5, 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_insn !== 32'h2941_FFFF || bus.out_err !== 1'b0 || bus.err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL addi_neg1: got insn=%h err=%b sticky=%b, expected 2941ffff 0 0",
                     bus.out_insn, bus.out_err, bus.err_sticky);
        end
        send(6, 5, 0, 0, 0, 32'd70000, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_insn !== 32'h2941_1170 || bus.out_err !== 1'b1 || bus.err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL addi_range: got insn=%h err=%b sticky=%b, expected 29411170 1 1",
                     bus.out_insn, bus.out_err, bus.err_sticky);
        end
        send(13, 2, 3, 0, 0, 32'hFFFF_0000, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL blt_min_imm: got err=%b sticky=%b, expected 0 1", bus.out_err, bus.err_sticky);
        end
        send(15, 0, 0, 0, 0, 32'd0, 32'h0800_0000, 1'b0, 12'h0);
        send(7, 1, 2, 0, 0, 32'd65535, 32'd0, 1'b0, 12'h0);
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (bus.err_sticky !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL sticky_hold: got sticky=%b valid=%b, expected 1 0", bus.err_sticky, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        send(9, 0, 0, 0, 0, 32'd0, 32'd100, 1'b0, 12'h0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_insn !== 32'h0800_0064 || bus.out_addr !== 12'h000 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got valid=%b insn=%h addr=%h in_ready=%b, expected 1 08000064 000 0",
                         i, bus.out_valid, bus.out_insn, bus.out_addr, bus.in_ready);
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b, expected 1", bus.in_ready);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.insn_count !== 16'd1) begin
            fails++;
            $display("FAIL bp_done: got valid=%b count=%0d, expected 0 1", bus.out_valid, bus.insn_count);
        end
    endtask

    task automatic test_addr_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        send(0, 1, 1, 1, 0, 32'd0, 32'd0, 1'b1, 12'hFFF);
        tests++;
        if (bus.out_addr !== 12'hFFF) begin
            fails++;
            $display("FAIL load_addr: got %h, expected fff", bus.out_addr);
        end
        send(3, 2, 2, 2, 0, 32'd0, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_addr !== 12'h000) begin
            fails++;
            $display("FAIL wrap_addr: got %h, expected 000", bus.out_addr);
        end
        send(5, 7, 8, 31, 31, 32'd0, 32'd0, 1'b0, 12'h0);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        send(8, 1, 1, 0, 0, 32'hFFFE_0000, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.err_sticky !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: got sticky=%b valid=%b, expected 1 1", bus.err_sticky, bus.out_valid);
        end
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b0 || bus.insn_count !== 16'd0 || bus.out_addr !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset: got valid=%b sticky=%b count=%0d addr=%h, expected 0 0 0 000",
                     bus.out_valid, bus.err_sticky, bus.insn_count, bus.out_addr);
        end
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_addr  = 12'h000;
        exp_count = 0;
        bus.out_ready = 1'b1;
        send(2, 9, 10, 11, 0, 32'd0, 32'd0, 1'b0, 12'h0);
        tests++;
        if (bus.out_addr !== 12'h000) begin
            fails++;
            $display("FAIL mid_counter: got addr=%h, expected 000", bus.out_addr);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_imm_range();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending words, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
